// File: rtl/mips_bus_fabric_pkg.sv
// Shared types and helpers for the MIPS memory-mapped bus fabric.
// Optional error-address capture is enabled with MIPS_BUS_ERR_CAPTURE_EN.
package mips_bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Width of a counter that must hold 0 .. cycles-1 (at least one bit).
    function automatic int wd_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mips_bus_fabric_watchdog.sv
// Saturating wait-state counter for the bus fabric. With TIMEOUT_CYCLES=0 the
// counter never leaves zero and expire stays low.
module bus_watchdog
    import mips_bus_fabric_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int W = wd_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last = (count == LAST);
    assign expire  = (TIMEOUT_CYCLES != 0) && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_bus_fabric.sv
// Memory-mapped interconnect between the MIPS data port and N_SLAVES peripherals.
// Define MIPS_BUS_ERR_CAPTURE_EN to latch the address of the first error response.
module mips_bus_fabric
    import mips_bus_fabric_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_SLAVES       = 4,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(BUS_ERR_DATA)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_req,
    input  logic [ADDR_WIDTH-1:0]          m_addr,
    input  logic [DATA_WIDTH-1:0]          m_wr_data,
    input  logic                           m_wr_en,
    output logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_rd_data,
    output logic                           m_err,
    output logic [N_SLAVES-1:0]            s_sel,
    output logic [ADDR_WIDTH-SEL_BITS-1:0] s_addr,
    output logic [DATA_WIDTH-1:0]          s_wr_data,
    output logic                           s_wr_en,
    input  logic [N_SLAVES-1:0]            s_ready,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rd_data,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    input  logic                           err_clr
);

    localparam int LW = ADDR_WIDTH - SEL_BITS;

    bus_state_t            state;
    logic [SEL_BITS-1:0]   slot_q;
    logic [SEL_BITS-1:0]   req_slot;
    logic                  req_mapped;
    logic [N_SLAVES-1:0]   req_onehot;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  wd_clear;
    logic                  wd_count;
    logic                  wd_expire;

    // Decode the incoming slot and pick out the ready/data of the latched slot;
    // ready from any other slave never reaches the FSM.
    always_comb begin
        req_slot   = m_addr[ADDR_WIDTH-1 -: SEL_BITS];
        req_mapped = (int'(req_slot) < N_SLAVES);
        req_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (req_slot == SEL_BITS'(i)) begin
                req_onehot[i] = 1'b1;
            end
            if (slot_q == SEL_BITS'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wd_clear = (state == IDLE);
    assign wd_count = (state == ACCESS) && !sel_ready;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .count_en(wd_count),
        .expire  (wd_expire)
    );

    // Transfer FSM; every master- and slave-facing output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot_q    <= '0;
            m_ready   <= 1'b0;
            m_rd_data <= '0;
            m_err     <= 1'b0;
            s_sel     <= '0;
            s_addr    <= '0;
            s_wr_data <= '0;
            s_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    if (m_req) begin
                        slot_q <= req_slot;
                        if (req_mapped) begin
                            state     <= ACCESS;
                            s_sel     <= req_onehot;
                            s_addr    <= m_addr[LW-1:0];
                            s_wr_data <= m_wr_data;
                            s_wr_en   <= m_wr_en;
                        end else begin
                            state     <= ERR;
                            m_ready   <= 1'b1;
                            m_err     <= 1'b1;
                            m_rd_data <= ERR_DATA;
                        end
                    end
                end
                ACCESS: begin
                    // A slave finishing on the timeout cycle still wins.
                    if (sel_ready || wd_expire) begin
                        state     <= RESP;
                        m_ready   <= 1'b1;
                        m_err     <= !sel_ready;
                        m_rd_data <= !sel_ready ? ERR_DATA : (s_wr_en ? '0 : sel_rdata);
                        s_sel     <= '0;
                        s_addr    <= '0;
                        s_wr_data <= '0;
                        s_wr_en   <= 1'b0;
                    end
                end
                RESP, ERR: begin
                    m_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MIPS_BUS_ERR_CAPTURE_EN
    logic                  err_event;
    logic [ADDR_WIDTH-1:0] err_event_addr;
    logic                  err_sticky;

    // An error response is decided either on an unmapped request or on a timeout.
    always_comb begin
        err_event      = (state == IDLE && m_req && !req_mapped) ||
                         (state == ACCESS && !sel_ready && wd_expire);
        err_event_addr = (state == IDLE) ? m_addr : {slot_q, s_addr};
    end

    // First error sticks until cleared; a clear coinciding with a new error keeps the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr   <= '0;
            err_sticky <= 1'b0;
        end else if (err_event && (!err_sticky || err_clr)) begin
            err_addr   <= err_event_addr;
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_addr   <= '0;
            err_sticky <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_mips_bus_fabric.sv
// Self-checking bench for mips_bus_fabric (3 slaves on 4 slots, 16-cycle timeout).
// Covers the capture register when built with MIPS_BUS_ERR_CAPTURE_EN.
module tb_mips_bus_fabric;

    localparam int TB_SLAVES  = 3;
    localparam int TB_TIMEOUT = 16;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          wait_cycles;
        logic [31:0] slave_rdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wr_data;
    logic        m_wr_en;
    logic        m_ready;
    logic [31:0] m_rd_data;
    logic        m_err;
    logic [2:0]  s_sel;
    logic [29:0] s_addr;
    logic [31:0] s_wr_data;
    logic        s_wr_en;
    logic [2:0]  s_ready;
    logic [95:0] s_rd_data;
    logic [31:0] err_addr;
    logic        err_clr;

    int          n_cmp;
    int          n_fail;
    int          slave_wait [TB_SLAVES];
    logic [31:0] slave_data [TB_SLAVES];
    bit          noise;

    mips_bus_fabric #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .N_SLAVES      (TB_SLAVES),
        .SEL_BITS      (2),
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wr_data(m_wr_data),
        .m_wr_en  (m_wr_en),
        .m_ready  (m_ready),
        .m_rd_data(m_rd_data),
        .m_err    (m_err),
        .s_sel    (s_sel),
        .s_addr   (s_addr),
        .s_wr_data(s_wr_data),
        .s_wr_en  (s_wr_en),
        .s_ready  (s_ready),
        .s_rd_data(s_rd_data),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave behaviour: the selected slave raises ready after its wait count;
    // unselected slaves produce junk when noise is on.
    initial begin
        int cnt;
        cnt       = 0;
        s_ready   = '0;
        s_rd_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < TB_SLAVES; i++) begin
                if (s_sel[i]) begin
                    s_ready[i]             = (cnt >= slave_wait[i]);
                    s_rd_data[i*32 +: 32]  = slave_data[i];
                end else begin
                    s_ready[i]             = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    s_rd_data[i*32 +: 32]  = noise ? 32'($urandom) : 32'h0;
                end
            end
            cnt = (s_sel != 3'b000) ? cnt + 1 : 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected response derived from the address map, the slave wait count and the timeout.
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        int   slot;
        r    = v;
        slot = int'(v.addr[31:30]);
        if (slot >= TB_SLAVES) begin
            r.exp_lat   = 1;
            r.exp_err   = 1'b1;
            r.exp_rdata = 32'hDEAD_BEEF;
        end else if (v.wait_cycles <= TB_TIMEOUT - 1) begin
            r.exp_lat   = 2 + v.wait_cycles;
            r.exp_err   = 1'b0;
            r.exp_rdata = v.wr ? 32'h0 : v.slave_rdata;
        end else begin
            r.exp_lat   = TB_TIMEOUT + 1;
            r.exp_err   = 1'b1;
            r.exp_rdata = 32'hDEAD_BEEF;
        end
        return r;
    endfunction

    // Issues one request from IDLE (called at a negedge) and checks it end to end.
    task automatic applyStimulus(input string name, input vec_t v);
        int          slot;
        int          lat;
        bit          got;
        logic [2:0]  exp_sel;
        slot = int'(v.addr[31:30]);
        if (slot < TB_SLAVES) begin
            slave_wait[slot] = v.wait_cycles;
            slave_data[slot] = v.slave_rdata;
            exp_sel          = 3'b001 << slot;
        end else begin
            exp_sel = 3'b000;
        end
        m_req     = 1'b1;
        m_addr    = v.addr;
        m_wr_en   = v.wr;
        m_wr_data = v.wdata;
        lat       = 0;
        got       = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checkOutput({name, " s_sel"}, 32'(s_sel), 32'(exp_sel));
                if (slot < TB_SLAVES) begin
                    checkOutput({name, " s_addr"}, 32'(s_addr), {2'b00, v.addr[29:0]});
                    checkOutput({name, " s_wr_en"}, 32'(s_wr_en), 32'(v.wr));
                    checkOutput({name, " s_wr_data"}, s_wr_data, v.wdata);
                end
            end
            if (m_ready) begin
                got   = 1'b1;
                m_req = 1'b0;
                checkOutput({name, " latency"}, 32'(lat), 32'(v.exp_lat));
                checkOutput({name, " m_err"}, 32'(m_err), 32'(v.exp_err));
                checkOutput({name, " m_rd_data"}, m_rd_data, v.exp_rdata);
                checkOutput({name, " s_sel at ready"}, 32'(s_sel), 32'h0);
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: no m_ready within %0d cycles, expected at cycle %0d", name, lat, v.exp_lat);
        end
        m_req = 1'b0;
        @(negedge clk);
        checkOutput({name, " ready pulse width"}, 32'(m_ready), 32'h0);
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    vec_t vecs [8];
    vec_t rv;
    int   waits [8] = '{0, 1, 2, 3, 4, 15, 16, 20};
    int   pulses;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        noise     = 1'b0;
        rst       = 1'b1;
        m_req     = 1'b0;
        m_addr    = '0;
        m_wr_data = '0;
        m_wr_en   = 1'b0;
        err_clr   = 1'b0;
        for (int i = 0; i < TB_SLAVES; i++) begin
            slave_wait[i] = 0;
            slave_data[i] = '0;
        end

        //            addr          wr    wdata         wait  sdata         lat err  rdata
        vecs[0] = '{32'h4000_0010, 1'b0, 32'h0,        0,    32'h1234_5678, 2, 1'b0, 32'h1234_5678};
        vecs[1] = '{32'h0000_0020, 1'b1, 32'hA5A5_A5A5, 3,   32'h5555_5555, 5, 1'b0, 32'h0};
        vecs[2] = '{32'hC000_0000, 1'b0, 32'h0,        0,    32'h0,         1, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{32'h8000_0040, 1'b0, 32'h0,        1000, 32'h7777_7777, 17, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{32'h8000_0044, 1'b0, 32'h0,        15,   32'hCAFE_0001, 17, 1'b0, 32'hCAFE_0001};
        vecs[5] = '{32'h4000_0100, 1'b0, 32'h0,        16,   32'h1111_2222, 17, 1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{32'h3FFF_FFFC, 1'b0, 32'h0,        1,    32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D};
        vecs[7] = '{32'h8000_0000, 1'b1, 32'h1357_9BDF, 0,   32'hFFFF_FFFF, 2, 1'b0, 32'h0};

        repeat (3) @(negedge clk);
        checkOutput("reset m_ready", 32'(m_ready), 32'h0);
        checkOutput("reset m_err", 32'(m_err), 32'h0);
        checkOutput("reset m_rd_data", m_rd_data, 32'h0);
        checkOutput("reset s_sel", 32'(s_sel), 32'h0);
        checkOutput("reset s_addr", 32'(s_addr), 32'h0);
        checkOutput("reset s_wr_en", 32'(s_wr_en), 32'h0);
        checkOutput("reset err_addr", err_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of an access drops it without a response.
        slave_wait[2] = 1000;
        m_req  = 1'b1;
        m_addr = 32'h8000_0008;
        m_wr_en = 1'b1;
        m_wr_data = 32'hFACE_FACE;
        repeat (4) @(negedge clk);
        checkOutput("midreset s_sel before", 32'(s_sel), 32'h4);
        rst = 1'b1;
        #1;
        checkOutput("midreset m_ready", 32'(m_ready), 32'h0);
        checkOutput("midreset m_rd_data", m_rd_data, 32'h0);
        checkOutput("midreset s_sel", 32'(s_sel), 32'h0);
        checkOutput("midreset s_addr", 32'(s_addr), 32'h0);
        checkOutput("midreset s_wr_en", 32'(s_wr_en), 32'h0);
        checkOutput("midreset s_wr_data", s_wr_data, 32'h0);
        m_req = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_ready) pulses++;
        end
        checkOutput("midreset stray m_ready", 32'(pulses), 32'h0);
        rv = '{32'h4000_0ABC, 1'b0, 32'h0, 2, 32'h2468_ACE0, 0, 1'b0, 32'h0};
        applyStimulus("after reset", refModel(rv));

`ifdef MIPS_BUS_ERR_CAPTURE_EN
        pulseErrClr();
        checkOutput("cap cleared", err_addr, 32'h0);
        rv = '{32'hC000_0004, 1'b0, 32'h0, 0, 32'h0, 0, 1'b0, 32'h0};
        applyStimulus("cap err1", refModel(rv));
        checkOutput("cap first", err_addr, 32'hC000_0004);
        rv.addr = 32'hC000_0008;
        applyStimulus("cap err2", refModel(rv));
        checkOutput("cap sticky", err_addr, 32'hC000_0004);
        pulseErrClr();
        checkOutput("cap clr", err_addr, 32'h0);
        applyStimulus("cap err3", refModel(rv));
        checkOutput("cap new", err_addr, 32'hC000_0008);
        pulseErrClr();
        rv = '{32'h8000_0ABC, 1'b0, 32'h0, 1000, 32'h0, 0, 1'b0, 32'h0};
        applyStimulus("cap timeout", refModel(rv));
        checkOutput("cap timeout addr", err_addr, 32'h8000_0ABC);
`else
        rv = '{32'hC000_0004, 1'b0, 32'h0, 0, 32'h0, 0, 1'b0, 32'h0};
        applyStimulus("nocap err", refModel(rv));
        pulseErrClr();
        checkOutput("nocap err_addr", err_addr, 32'h0);
`endif

        // Random traffic with junk on the unselected slave ports.
        noise = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rv.addr        = 32'($urandom);
            rv.wr          = 1'($urandom_range(0, 1));
            rv.wdata       = 32'($urandom);
            rv.wait_cycles = waits[$urandom_range(0, 7)];
            rv.slave_rdata = 32'($urandom);
            applyStimulus($sformatf("rand%0d", n), refModel(rv));
        end
        noise = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
